// File: rtl/contadores_pkg.sv
// Shared constants and state encoding for the counter readout initiator.
package contadores_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_WAIT = 2'd0;
  localparam state_t S_REQ  = 2'd1;
  localparam state_t S_GAP  = 2'd2;
  localparam state_t S_DONE = 2'd3;

  localparam int NUM_CNT_DEF = 5;
  localparam int DATA_W_DEF  = 5;
  localparam int TOUT_DEF    = 15;
  localparam int IDX_W       = 3;
  localparam int TOT_W       = 8;

endpackage

// File: rtl/lector_timeout.sv
// Loadable down-counter watchdog; expire fires in the enabled cycle that would
// take the count from 1 to 0, so a load of N allows exactly N enabled cycles.
module lector_timeout #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = en && !load && (cnt == W'(1));

endmodule

// File: rtl/contadores_lector.sv
// Readout initiator sweeping the pop-counter block and summing the counts.
// Optional macro CONTADORES_LECTOR_CLR_EN adds a clr pulse alongside done.
//
//   state  | meaning
//   S_WAIT | idle, waiting for start while IDLE is high
//   S_REQ  | req high for the current idx, waiting for valid or timeout
//   S_GAP  | one req-low cycle between indices
//   S_DONE | publish total, strobe done
module contadores_lector
  import contadores_pkg::*;
#(
  parameter int NUM_CNT = NUM_CNT_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TOUT    = TOUT_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              IDLE,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              req,
  output logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TOT_W-1:0]  total,
  output logic              busy,
  output logic              done,
  output logic              tout_err
`ifdef CONTADORES_LECTOR_CLR_EN
  ,
  output logic              clr
`endif
);

  localparam int TW = $clog2(TOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

  if (NUM_CNT < 1 || NUM_CNT > 8) begin : g_bad_num_cnt
    $error("contadores_lector: NUM_CNT must be in 1..8");
  end
  if (TOUT < 1) begin : g_bad_tout
    $error("contadores_lector: TOUT must be at least 1");
  end

  state_t            state;
  logic [TOT_W-1:0]  acc;
  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_expire;

  // Timer reloads in every non-request cycle, so each S_REQ entry starts fresh.
  assign tmr_load = (state != S_REQ);
  assign tmr_en   = (state == S_REQ) && !valid;

  lector_timeout #(.W(TW)) u_timeout (
    .CLK      (CLK),
    .reset    (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (TW'(TOUT)),
    .expire   (tmr_expire)
  );

  assign req = (state == S_REQ);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= S_WAIT;
      idx      <= '0;
      rd_data  <= '0;
      rd_idx   <= '0;
      rd_valid <= 1'b0;
      total    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tout_err <= 1'b0;
      acc      <= '0;
`ifdef CONTADORES_LECTOR_CLR_EN
      clr      <= 1'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
`ifdef CONTADORES_LECTOR_CLR_EN
      clr      <= 1'b0;
`endif
      case (state)
        S_WAIT: begin
          if (start && IDLE) begin
            state    <= S_REQ;
            idx      <= '0;
            busy     <= 1'b1;
            tout_err <= 1'b0;
            acc      <= '0;
          end
        end
        S_REQ: begin
          // valid takes priority over a same-cycle timer expiry
          if (valid) begin
            rd_data  <= data;
            rd_idx   <= idx;
            rd_valid <= 1'b1;
            acc      <= acc + TOT_W'(data);
            state    <= S_GAP;
          end else if (tmr_expire) begin
            tout_err <= 1'b1;
            busy     <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_GAP: begin
          if (idx == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= S_REQ;
          end
        end
        S_DONE: begin
          total <= acc;
          done  <= 1'b1;
          busy  <= 1'b0;
`ifdef CONTADORES_LECTOR_CLR_EN
          clr   <= 1'b1;
`endif
          state <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_contadores_lector.sv
// Randomized self-checking bench for contadores_lector with a procedural responder.
module tb_contadores_lector;

  localparam int NUM  = 5;
  localparam int DW   = 5;
  localparam int TOUT = 15;

  logic          CLK = 1'b0;
  logic          reset;
  logic          IDLE;
  logic          start;
  logic [DW-1:0] data;
  logic          valid;
  logic          req;
  logic [2:0]    idx;
  logic [DW-1:0] rd_data;
  logic [2:0]    rd_idx;
  logic          rd_valid;
  logic [7:0]    total;
  logic          busy;
  logic          done;
  logic          tout_err;
`ifdef CONTADORES_LECTOR_CLR_EN
  logic          clr;
`endif

  always #5 CLK = ~CLK;

  contadores_lector #(.NUM_CNT(NUM), .DATA_W(DW), .TOUT(TOUT)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .IDLE     (IDLE),
    .start    (start),
    .data     (data),
    .valid    (valid),
    .req      (req),
    .idx      (idx),
    .rd_data  (rd_data),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .total    (total),
    .busy     (busy),
    .done     (done),
    .tout_err (tout_err)
`ifdef CONTADORES_LECTOR_CLR_EN
    ,
    .clr      (clr)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int rsp_data [NUM];
  int rsp_dly  [NUM];
  int exp_total;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
  endtask

  // Runs one sweep from a negedge. silent: index that never answers (-1 none).
  // rst_at: index at which reset is pulsed mid-request (-1 none).
  task automatic do_sweep(input int silent, input int rst_at, input bit inject);
    int sum;
    int hi;
    sum   = 0;
    IDLE  = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("tout_clr", tout_err, 0);
    for (int i = 0; i < NUM; i++) begin
      chk("req_on", req, 1);
      chk("idx", idx, i);
      chk("busy", busy, 1);
      chk("rd_valid_1cyc", rd_valid, 0);
      if (i == rst_at) begin
        #2 reset = 1'b0;
        #1;
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_total", total, 0);
        chk("rst_idx", idx, 0);
        chk("rst_rd_data", rd_data, 0);
        exp_total = 0;
        tick;
        reset = 1'b1;
        tick;
        return;
      end
      if (i == silent) begin
        hi = 0;
        while (req === 1'b1 && hi < TOUT + 5) begin
          hi++;
          tick;
        end
        chk("tout_len", hi, TOUT);
        chk("tout_err", tout_err, 1);
        chk("busy_abort", busy, 0);
        repeat (3) begin
          chk("no_done", done, 0);
          chk("req_idle", req, 0);
          tick;
        end
        chk("total_kept", total, exp_total);
        chk("tout_sticky", tout_err, 1);
        return;
      end
      repeat (rsp_dly[i]) begin
        if (inject) start = ($urandom_range(0, 1) == 1);
        tick;
        start = 1'b0;
        chk("req_hold", req, 1);
        chk("no_early_rd", rd_valid, 0);
      end
      valid = 1'b1;
      data  = DW'(rsp_data[i]);
      tick;
      valid = 1'b0;
      data  = DW'($urandom);
      chk("req_gap", req, 0);
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, rsp_data[i]);
      chk("rd_idx", rd_idx, i);
      sum += rsp_data[i];
      valid = ($urandom_range(0, 1) == 1);
      tick;
      valid = 1'b0;
    end
    chk("done_early", done, 0);
    chk("req_in_done", req, 0);
    start = inject;
    tick;
    start = 1'b0;
    chk("done", done, 1);
    chk("total", total, sum);
    chk("busy_end", busy, 0);
`ifdef CONTADORES_LECTOR_CLR_EN
    chk("clr", clr, 1);
`endif
    exp_total = sum;
    tick;
    chk("done_pulse", done, 0);
    chk("req_after", req, 0);
    chk("busy_after", busy, 0);
`ifdef CONTADORES_LECTOR_CLR_EN
    chk("clr_pulse", clr, 0);
`endif
  endtask

  task automatic set_rand(input int dmax);
    for (int i = 0; i < NUM; i++) begin
      rsp_data[i] = $urandom_range(0, 31);
      rsp_dly[i]  = ($urandom_range(0, 3) == 0) ? TOUT - 1 : $urandom_range(0, dmax);
    end
  endtask

  initial begin
    int nom [NUM];
    nom = '{3, 7, 0, 31, 12};
    reset = 1'b0; IDLE = 1'b0; start = 1'b0; valid = 1'b0; data = '0;
    exp_total = 0;
    repeat (2) tick;
    chk("rst_req", req, 0);
    chk("rst_idx", idx, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_total", total, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tout", tout_err, 0);
    reset = 1'b1;
    tick;

    // nominal 1-cycle responder
    for (int i = 0; i < NUM; i++) begin rsp_data[i] = nom[i]; rsp_dly[i] = 0; end
    do_sweep(-1, -1, 1'b0);
    chk("total_53", total, 53);

    // timeout on idx 2, total must stay 53
    do_sweep(2, -1, 1'b0);
    chk("total_still_53", total, 53);

    // slow responder
    for (int i = 0; i < NUM; i++) begin rsp_data[i] = $urandom_range(0, 31); rsp_dly[i] = 4; end
    do_sweep(-1, -1, 1'b0);

    // start with IDLE low is ignored; stray valid while idle is ignored
    IDLE  = 1'b0;
    start = 1'b1;
    valid = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) begin
      chk("gated_req", req, 0);
      chk("gated_busy", busy, 0);
      chk("stray_rd", rd_valid, 0);
      tick;
    end
    valid = 1'b0;

    // start injected during the sweep, and valid exactly at the timeout limit
    set_rand(6);
    rsp_dly[1] = TOUT - 1;
    do_sweep(-1, -1, 1'b1);

    // async reset during idx 3, then a full sweep
    set_rand(2);
    do_sweep(-1, 3, 1'b0);
    chk("post_rst_total", total, 0);
    set_rand(3);
    do_sweep(-1, -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      set_rand(5);
      do_sweep(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NUM - 1)) : -1, -1,
               ($urandom_range(0, 1) == 1));
      repeat ($urandom_range(0, 3)) tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
